// File: rtl/waveform_buffer_pkg.sv
// waveform_buffer_pkg: display-wide constants shared by the trace buffer and the waveform renderer.
package waveform_buffer_pkg;
    localparam int SCREEN_WIDTH = 1024;
    localparam int SAMPLE_W     = 8;
    localparam int PIPE_LAT     = 2;
    localparam int HCOUNT_W     = 11;
endpackage

// File: rtl/trace_ram.sv
// trace_ram: simple dual-port sample RAM, sync write, registered read-first read (1-cycle latency).
module trace_ram #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/waveform_buffer.sv
// waveform_buffer: circular store of decimated samples, streamed per column (oldest first)
// with a 2-cycle read pipeline aligned to a delayed hcount.
module waveform_buffer
    import waveform_buffer_pkg::*;
#(
    parameter int DEPTH    = SCREEN_WIDTH,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int DATA_W   = SAMPLE_W,
    parameter int DECIMATE = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DATA_W-1:0]   sample_in,
    input  logic                sample_valid,
    input  logic                freeze,
    input  logic                frame_start,
    input  logic [HCOUNT_W-1:0] hcount,
    output logic [DATA_W-1:0]   sample_out,
    output logic                sample_out_vld,
    output logic [HCOUNT_W-1:0] out_hcount,
    output logic [ADDR_W:0]     fill_count
);
    localparam int DEC_W  = DECIMATE > 1 ? $clog2(DECIMATE) : 1;
    localparam int FILL_W = ADDR_W + 1;

    logic [DEC_W-1:0]    dec_cnt_q, dec_cnt_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d, base_q, base_d, rd_addr;
    logic [FILL_W-1:0]   fill_q, fill_d, frame_fill_q, frame_fill_d;
    logic                in_rng_q, in_rng_d, vld_q, accept, wr_en, full;
    logic [HCOUNT_W-1:0] hcount_d1_q, out_hcount_q;
    logic [DATA_W-1:0]   rd_data, sample_out_q, sample_out_d;

    always_comb begin
        accept       = sample_valid && !freeze;
        wr_en        = accept && dec_cnt_q == '0;
        full         = fill_q == FILL_W'(DEPTH);
        dec_cnt_d    = !accept ? dec_cnt_q : (dec_cnt_q == DEC_W'(DECIMATE - 1)) ? '0 : dec_cnt_q + 1'b1;
        wr_ptr_d     = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        fill_d       = (wr_en && !full) ? fill_q + 1'b1 : fill_q;
        // Snapshot sees pre-write state; until the buffer wraps the oldest sample sits at address 0.
        base_d       = frame_start ? (full ? wr_ptr_q : '0) : base_q;
        frame_fill_d = frame_start ? fill_q : frame_fill_q;
        rd_addr      = base_q + hcount[ADDR_W-1:0];
        in_rng_d     = 32'(hcount) < 32'(frame_fill_q);
        sample_out_d = in_rng_q ? rd_data : '0;
    end

    // RAM output register is the first read stage, so raddr comes straight from hcount.
    trace_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata (sample_in),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dec_cnt_q    <= '0;
            wr_ptr_q     <= '0;
            fill_q       <= '0;
            base_q       <= '0;
            frame_fill_q <= '0;
            in_rng_q     <= 1'b0;
            hcount_d1_q  <= '0;
            sample_out_q <= '0;
            vld_q        <= 1'b0;
            out_hcount_q <= '0;
        end else begin
            dec_cnt_q    <= dec_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            fill_q       <= fill_d;
            base_q       <= base_d;
            frame_fill_q <= frame_fill_d;
            in_rng_q     <= in_rng_d;
            hcount_d1_q  <= hcount;
            sample_out_q <= sample_out_d;
            vld_q        <= in_rng_q;
            out_hcount_q <= hcount_d1_q;
        end
    end

    assign sample_out     = sample_out_q;
    assign sample_out_vld = vld_q;
    assign out_hcount     = out_hcount_q;
    assign fill_count     = fill_q;
endmodule

// File: tb/tb_waveform_buffer.sv
// tb_waveform_buffer: two 16-deep instances (DECIMATE 1 and 4) on shared stimulus, checked
// against a behavioural model through a scoreboard queue plus table-driven column vectors.
module tb_waveform_buffer;
    logic        clk = 0, reset = 0, sample_valid = 0, freeze = 0, frame_start = 0;
    logic [7:0]  sample_in = 0;
    logic [10:0] hcount = 0;
    logic [7:0]  so_a, so_b;
    logic        sv_a, sv_b;
    logic [10:0] oh_a, oh_b;
    logic [4:0]  fc_a, fc_b;

    int n_vec = 0, n_fail = 0;

    waveform_buffer #(.DEPTH(16), .ADDR_W(4), .DATA_W(8), .DECIMATE(1)) dut_a (
        .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
        .freeze(freeze), .frame_start(frame_start), .hcount(hcount),
        .sample_out(so_a), .sample_out_vld(sv_a), .out_hcount(oh_a), .fill_count(fc_a));
    waveform_buffer #(.DEPTH(16), .ADDR_W(4), .DATA_W(8), .DECIMATE(4)) dut_b (
        .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
        .freeze(freeze), .frame_start(frame_start), .hcount(hcount),
        .sample_out(so_b), .sample_out_vld(sv_b), .out_hcount(oh_b), .fill_count(fc_b));

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] h;
        logic [7:0]  d0, d1;
        logic        v0, v1;
    } exp_t;
    exp_t q[$];

    typedef struct {
        logic [10:0] h;
        logic [7:0]  d;
        logic        v;
    } vec_t;
    vec_t tab[6];

    int         m_wp[2], m_fill[2], m_base[2], m_ffill[2], m_dec[2];
    int         dec_n[2] = '{1, 4};
    logic [7:0] m_mem[2][16];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_wp[i] = 0; m_fill[i] = 0; m_base[i] = 0; m_ffill[i] = 0; m_dec[i] = 0;
        end
        q.delete();
    endtask

    task automatic do_reset();
        reset = 1;
        #1;
        chk("rst_out_a", int'(so_a), 0);  chk("rst_vld_a", int'(sv_a), 0);
        chk("rst_oh_a", int'(oh_a), 0);   chk("rst_fill_a", int'(fc_a), 0);
        chk("rst_out_b", int'(so_b), 0);  chk("rst_vld_b", int'(sv_b), 0);
        chk("rst_oh_b", int'(oh_b), 0);   chk("rst_fill_b", int'(fc_b), 0);
        model_reset();
        @(posedge clk); #1;
        reset = 0;
    endtask

    task automatic tick_x(input logic [10:0] h, input logic sv, input logic [7:0] sin,
                          input logic fz, input logic fs,
                          input logic ov, input logic [7:0] od, input logic ovld);
        exp_t e;
        logic v;
        hcount = h; sample_valid = sv; sample_in = sin; freeze = fz; frame_start = fs;
        e.h = h;
        v = int'(h) < m_ffill[0];
        e.v0 = v; e.d0 = v ? m_mem[0][(m_base[0] + int'(h)) % 16] : 8'd0;
        v = int'(h) < m_ffill[1];
        e.v1 = v; e.d1 = v ? m_mem[1][(m_base[1] + int'(h)) % 16] : 8'd0;
        if (ov) begin e.d0 = od; e.v0 = ovld; end
        q.push_back(e);
        for (int i = 0; i < 2; i++) begin
            if (fs) begin
                m_base[i]  = (m_fill[i] == 16) ? m_wp[i] : 0;
                m_ffill[i] = m_fill[i];
            end
            if (sv && !fz) begin
                if (m_dec[i] == 0) begin
                    m_mem[i][m_wp[i]] = sin;
                    m_wp[i] = (m_wp[i] + 1) % 16;
                    if (m_fill[i] < 16) m_fill[i]++;
                end
                m_dec[i] = (m_dec[i] == dec_n[i] - 1) ? 0 : m_dec[i] + 1;
            end
        end
        @(posedge clk); #1;
        sample_valid = 0; frame_start = 0;
        chk("fill_a", int'(fc_a), m_fill[0]);
        chk("fill_b", int'(fc_b), m_fill[1]);
        if (q.size() > 1) begin
            e = q.pop_front();
            chk("out_a", int'(so_a), int'(e.d0)); chk("vld_a", int'(sv_a), int'(e.v0));
            chk("oh_a", int'(oh_a), int'(e.h));
            chk("out_b", int'(so_b), int'(e.d1)); chk("vld_b", int'(sv_b), int'(e.v1));
            chk("oh_b", int'(oh_b), int'(e.h));
        end
    endtask

    task automatic tick(input logic [10:0] h, input logic sv, input logic [7:0] sin,
                        input logic fz, input logic fs);
        tick_x(h, sv, sin, fz, fs, 1'b0, 8'd0, 1'b0);
    endtask

    initial begin
        tab[0] = '{h: 11'd0,  d: 8'd10, v: 1'b1};
        tab[1] = '{h: 11'd1,  d: 8'd20, v: 1'b1};
        tab[2] = '{h: 11'd2,  d: 8'd30, v: 1'b1};
        tab[3] = '{h: 11'd3,  d: 8'd0,  v: 1'b0};
        tab[4] = '{h: 11'd4,  d: 8'd0,  v: 1'b0};
        tab[5] = '{h: 11'd20, d: 8'd0,  v: 1'b0};
        #2;
        // basic write/read with table-driven columns
        do_reset();
        tick(0, 1, 8'd10, 0, 0);
        tick(0, 1, 8'd20, 0, 0);
        tick(0, 1, 8'd30, 0, 0);
        tick(0, 0, 8'd0, 0, 1);
        for (int i = 0; i < 6; i++) tick_x(tab[i].h, 0, 8'd0, 0, 0, 1'b1, tab[i].d, tab[i].v);
        tick(0, 0, 8'd0, 0, 0);
        // decimation by 4
        do_reset();
        for (int i = 0; i < 8; i++) tick(0, 1, 8'(i), 0, 0);
        chk("dec_fill_b", int'(fc_b), 2);
        tick(0, 0, 8'd0, 0, 1);
        for (int i = 0; i < 3; i++) tick(11'(i), 0, 8'd0, 0, 0);
        tick(0, 0, 8'd0, 0, 0);
        // wrap: 20 writes into 16 entries, oldest (5) at column 0
        do_reset();
        for (int i = 1; i <= 20; i++) tick(0, 1, 8'(i), 0, 0);
        chk("wrap_fill_a", int'(fc_a), 16);
        tick(0, 0, 8'd0, 0, 1);
        tick_x(0, 0, 8'd0, 0, 0, 1'b1, 8'd5, 1'b1);
        for (int i = 1; i < 15; i++) tick(11'(i), 0, 8'd0, 0, 0);
        tick_x(15, 0, 8'd0, 0, 0, 1'b1, 8'd20, 1'b1);
        tick(16, 0, 8'd0, 0, 0);
        // freeze holds everything, release resumes
        do_reset();
        for (int i = 0; i < 3; i++) tick(0, 1, 8'(40 + i), 0, 0);
        for (int i = 0; i < 5; i++) tick(0, 1, 8'd99, 1, 0);
        chk("frz_fill_a", int'(fc_a), 3);
        chk("frz_fill_b", int'(fc_b), 1);
        for (int i = 0; i < 6; i++) tick(0, 1, 8'(50 + i), 0, 0);
        tick(0, 0, 8'd0, 0, 1);
        for (int i = 0; i < 10; i++) tick(11'(i), 0, 8'd0, 0, 0);
        tick(0, 0, 8'd0, 0, 0);
        // read-first collision: column 0 read while slot 0 is rewritten 7 -> 9
        do_reset();
        for (int i = 0; i < 16; i++) tick(0, 1, 8'd7, 0, 0);
        tick(0, 0, 8'd0, 0, 1);
        tick_x(0, 1, 8'd9, 0, 0, 1'b1, 8'd7, 1'b1);
        tick(1, 0, 8'd0, 0, 0);
        tick(0, 0, 8'd0, 0, 1);
        tick_x(15, 0, 8'd0, 0, 0, 1'b1, 8'd9, 1'b1);
        tick(0, 0, 8'd0, 0, 0);
        // reset mid-line, then nothing valid until write + frame_start
        for (int i = 0; i < 4; i++) tick(11'(i), 0, 8'd0, 0, 0);
        do_reset();
        for (int i = 0; i < 3; i++) tick(11'(i), 0, 8'd0, 0, 0);
        tick(0, 0, 8'd0, 0, 1);
        tick(0, 1, 8'd77, 0, 0);
        tick(0, 0, 8'd0, 0, 0);
        tick(0, 0, 8'd0, 0, 1);
        tick_x(0, 0, 8'd0, 0, 0, 1'b1, 8'd77, 1'b1);
        tick(1, 0, 8'd0, 0, 0);
        tick(0, 0, 8'd0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
